// File: rtl/fold_tap_reader_pkg.sv
// rtl/fold_tap_reader_pkg.sv - shared FSM encodings and tap flag record for the tap reader
package fold_tap_reader_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fold_defs_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tap_flags_t;

endpackage

// File: rtl/fold_tap_align.sv
// rtl/fold_tap_align.sv - clkEn-gated delay that lines tap flags up with RAM read data
module fold_tap_align
  import fold_tap_reader_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       nGrst,
  input  logic       rst,
  input  logic       clkEn,
  input  tap_flags_t din,
  output tap_flags_t dout
);

  tap_flags_t stage [RD_LATENCY];

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      for (int i = 0; i < RD_LATENCY; i++) stage[i] <= '0;
    end else if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) stage[i] <= '0;
    end else if (clkEn) begin
      stage[0] <= din;
      for (int i = 1; i < RD_LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[RD_LATENCY-1];

endmodule

// File: rtl/fold_tap_reader.sv
// rtl/fold_tap_reader.sv - walks the circular sample buffer newest to oldest for one FIR output
module fold_tap_reader
  import fold_tap_reader_pkg::*;
#(
  parameter int TAPS         = 16,
  parameter int LOGTAPS      = 4,
  parameter int RAM_LOGDEPTH = 5,
  parameter int RD_LATENCY   = 1
) (
  input  logic                    clk,
  input  logic                    nGrst,
  input  logic                    rst,
  input  logic                    clkEn,
  input  logic                    start,
  input  logic [RAM_LOGDEPTH-1:0] newest_addr,
  output logic [RAM_LOGDEPTH-1:0] raddr,
  output logic                    rdb,
  output logic [LOGTAPS-1:0]      coef_addr,
  output logic                    busy,
  output logic                    dout_valid,
  output logic                    dout_first,
  output logic                    dout_last,
  output logic                    overrun
);

  localparam logic [LOGTAPS-1:0] LAST_COEF = LOGTAPS'(TAPS - 1);

  if (TAPS > 2**RAM_LOGDEPTH || 2**LOGTAPS < TAPS) begin : g_param_err
    $error("fold_tap_reader: TAPS must fit both the buffer depth and coef_addr");
  end

  fold_defs_e              state_q, state_d;
  logic [RAM_LOGDEPTH-1:0] raddr_d;
  logic [LOGTAPS-1:0]      coef_d;
  logic                    rdb_d, overrun_d;
  logic                    last_tap;
  tap_flags_t              flags_a, flags_d;

  assign last_tap = (coef_addr == LAST_COEF);

  always_comb begin
    state_d   = state_q;
    raddr_d   = raddr;
    coef_d    = coef_addr;
    rdb_d     = rdb;
    overrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          raddr_d = newest_addr;
          coef_d  = '0;
          rdb_d   = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!last_tap) begin
          // Natural wrap of the address width gives the circular-buffer walk.
          raddr_d   = raddr - RAM_LOGDEPTH'(1);
          coef_d    = coef_addr + LOGTAPS'(1);
          overrun_d = start;
        end else if (start) begin
          raddr_d = newest_addr;
          coef_d  = '0;
        end else begin
          raddr_d = '0;
          coef_d  = '0;
          rdb_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      state_q   <= ST_IDLE;
      raddr     <= '0;
      coef_addr <= '0;
      rdb       <= 1'b0;
      overrun   <= 1'b0;
    end else if (rst) begin
      state_q   <= ST_IDLE;
      raddr     <= '0;
      coef_addr <= '0;
      rdb       <= 1'b0;
      overrun   <= 1'b0;
    end else if (clkEn) begin
      state_q   <= state_d;
      raddr     <= raddr_d;
      coef_addr <= coef_d;
      rdb       <= rdb_d;
      overrun   <= overrun_d;
    end
  end

  assign busy    = rdb;
  assign flags_a = '{valid: rdb, first: rdb && (coef_addr == '0), last: rdb && last_tap};

  fold_tap_align #(.RD_LATENCY(RD_LATENCY)) u_align (
    .clk   (clk),
    .nGrst (nGrst),
    .rst   (rst),
    .clkEn (clkEn),
    .din   (flags_a),
    .dout  (flags_d)
  );

  assign dout_valid = flags_d.valid;
  assign dout_first = flags_d.first;
  assign dout_last  = flags_d.last;

endmodule

// File: tb/tb_fold_tap_reader.sv
// tb/tb_fold_tap_reader.sv - self-checking bench for fold_tap_reader at read latencies 1 and 3
module tb_fold_tap_reader;

  localparam int TAPS  = 16;
  localparam int DEPTH = 32;

  logic       clk, nGrst, rst, clkEn, start;
  logic [4:0] newest_addr;
  logic [4:0] raddr1, raddr3;
  logic [3:0] coef1, coef3;
  logic       rdb1, busy1, dv1, df1, dl1, ov1;
  logic       rdb3, busy3, dv3, df3, dl3, ov3;

  fold_tap_reader #(.TAPS(16), .LOGTAPS(4), .RAM_LOGDEPTH(5), .RD_LATENCY(1)) dut1 (
    .clk(clk), .nGrst(nGrst), .rst(rst), .clkEn(clkEn), .start(start),
    .newest_addr(newest_addr), .raddr(raddr1), .rdb(rdb1), .coef_addr(coef1),
    .busy(busy1), .dout_valid(dv1), .dout_first(df1), .dout_last(dl1), .overrun(ov1));

  fold_tap_reader #(.TAPS(16), .LOGTAPS(4), .RAM_LOGDEPTH(5), .RD_LATENCY(3)) dut3 (
    .clk(clk), .nGrst(nGrst), .rst(rst), .clkEn(clkEn), .start(start),
    .newest_addr(newest_addr), .raddr(raddr3), .rdb(rdb3), .coef_addr(coef3),
    .busy(busy3), .dout_valid(dv3), .dout_first(df3), .dout_last(dl3), .overrun(ov3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Reference model: a read sequence is "tap k of a run based at m_base"
  bit         m_active, m_over;
  int         m_base, m_k;
  logic [2:0] p1[$], p3[$];

  int   q_valid, q_rdb, q_first, q_last, q_last3, q_ov;
  int   cap_new, cap_old, rise_rdb, rise_dv1, rise_dv3;
  logic sv_dv1, sv_df1, sv_dl1, sv_dl3, sv_rdb, sv_ov;

  typedef struct {
    int newest;
    int exp_new;
    int exp_old;
    int exp_reads;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    m_active = 0; m_over = 0; m_base = 0; m_k = 0;
    p1.delete(); p3.delete();
    p1.push_back(3'b000);
    for (int i = 0; i < 3; i++) p3.push_back(3'b000);
  endtask

  task automatic model_step();
    logic [2:0] cur;
    if (rst) model_reset();
    else if (clkEn) begin
      cur = {m_active, m_active && m_k == 0, m_active && m_k == TAPS-1};
      p1.push_back(cur); void'(p1.pop_front());
      p3.push_back(cur); void'(p3.pop_front());
      m_over = 0;
      if (!m_active) begin
        if (start) begin m_active = 1; m_base = newest_addr; m_k = 0; end
      end else if (m_k < TAPS-1) begin
        m_k++;
        if (start) m_over = 1;
      end else if (start) begin
        m_base = newest_addr; m_k = 0;
      end else m_active = 0;
    end
  endtask

  task automatic check_all();
    int e_addr, e_coef;
    e_addr = m_active ? ((m_base - m_k + DEPTH) % DEPTH) : 0;
    e_coef = m_active ? m_k : 0;
    chk("raddr", raddr1, e_addr);      chk("raddr_l3", raddr3, e_addr);
    chk("coef_addr", coef1, e_coef);   chk("coef_addr_l3", coef3, e_coef);
    chk("rdb", rdb1, m_active);        chk("rdb_l3", rdb3, m_active);
    chk("busy", busy1, m_active);      chk("busy_l3", busy3, m_active);
    chk("overrun", ov1, m_over);       chk("overrun_l3", ov3, m_over);
    chk("dout_valid", dv1, p1[0][2]);  chk("dout_valid_l3", dv3, p3[0][2]);
    chk("dout_first", df1, p1[0][1]);  chk("dout_first_l3", df3, p3[0][1]);
    chk("dout_last", dl1, p1[0][0]);   chk("dout_last_l3", dl3, p3[0][0]);
  endtask

  task automatic clear_stats();
    q_valid = 0; q_rdb = 0; q_first = 0; q_last = 0; q_last3 = 0; q_ov = 0;
    cap_new = -1; cap_old = -1; rise_rdb = -1; rise_dv1 = -1; rise_dv3 = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (clkEn && !rst) begin
      q_valid += int'(sv_dv1); q_first += int'(sv_df1); q_last += int'(sv_dl1);
      q_last3 += int'(sv_dl3); q_rdb += int'(sv_rdb); q_ov += int'(sv_ov);
    end
    model_step();
    #1;
    check_all();
    cyc++;
    sv_dv1 = dv1; sv_df1 = df1; sv_dl1 = dl1; sv_dl3 = dl3; sv_rdb = rdb1; sv_ov = ov1;
    if (rdb1 && coef1 == 4'd0) cap_new = int'(raddr1);
    if (rdb1 && coef1 == 4'd15) cap_old = int'(raddr1);
    if (rdb1 && rise_rdb < 0) rise_rdb = cyc;
    if (dv1 && rise_dv1 < 0) rise_dv1 = cyc;
    if (dv3 && rise_dv3 < 0) rise_dv3 = cyc;
  endtask

  task automatic do_start(input int addr);
    start = 1'b1; newest_addr = 5'(addr);
    tick();
    start = 1'b0;
  endtask

  task automatic run_out();
    for (int i = 0; i < 80; i++) begin
      if (!m_active && p3[0] == 3'b0 && p3[1] == 3'b0 && p3[2] == 3'b0) break;
      tick();
    end
    chk("drain_busy", busy1, 0);
    chk("drain_valid_l3", dv3, 0);
  endtask

  initial begin
    vecs[0] = '{10, 10, 27, 16};
    vecs[1] = '{0, 0, 17, 16};
    vecs[2] = '{31, 31, 16, 16};
    vecs[3] = '{15, 15, 0, 16};
    vecs[4] = '{5, 5, 22, 16};

    nGrst = 1'b0; rst = 1'b0; clkEn = 1'b0; start = 1'b0; newest_addr = '0;
    sv_dv1 = 0; sv_df1 = 0; sv_dl1 = 0; sv_dl3 = 0; sv_rdb = 0; sv_ov = 0;
    model_reset();
    clear_stats();
    #3;
    check_all();
    @(posedge clk); #1;
    check_all();
    nGrst = 1'b1; clkEn = 1'b1;
    tick();

    foreach (vecs[v]) begin
      clear_stats();
      do_start(vecs[v].newest);
      run_out();
      chk("tap0_addr", cap_new, vecs[v].exp_new);
      chk("tap15_addr", cap_old, vecs[v].exp_old);
      chk("reads", q_rdb, vecs[v].exp_reads);
      chk("valid_cnt", q_valid, vecs[v].exp_reads);
      chk("first_cnt", q_first, 1);
      chk("last_cnt", q_last, 1);
      chk("lag_l1", rise_dv1 - rise_rdb, 1);
      chk("lag_l3", rise_dv3 - rise_rdb, 3);
    end

    // back-to-back reload on the last tap
    clear_stats();
    do_start(10);
    repeat (15) tick();
    start = 1'b1; newest_addr = 5'd11;
    tick();
    start = 1'b0;
    chk("b2b_raddr", raddr1, 11);
    chk("b2b_coef", coef1, 0);
    chk("b2b_rdb", rdb1, 1);
    run_out();
    chk("b2b_valid_cnt", q_valid, 32);
    chk("b2b_reads", q_rdb, 32);
    chk("b2b_first_cnt", q_first, 2);
    chk("b2b_last_cnt", q_last, 2);

    // start mid-run is dropped and flagged
    clear_stats();
    do_start(20);
    repeat (5) tick();
    start = 1'b1; newest_addr = 5'd3;
    tick();
    start = 1'b0;
    chk("overrun_pulse", ov1, 1);
    tick();
    chk("overrun_clear", ov1, 0);
    run_out();
    chk("overrun_cnt", q_ov, 1);
    chk("overrun_reads", q_rdb, 16);
    chk("overrun_tap15", cap_old, 5);

    // clkEn low holds everything; a start seen only while clkEn=0 is ignored
    clear_stats();
    do_start(3);
    repeat (7) tick();
    chk("gate_coef", coef1, 7);
    clkEn = 1'b0; start = 1'b1; newest_addr = 5'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      start = 1'b0;
      chk("hold_coef", coef1, 7);
      chk("hold_raddr", raddr1, 28);
      chk("hold_valid", dv1, 1);
    end
    clkEn = 1'b1;
    run_out();
    chk("gate_reads", q_rdb, 16);
    chk("gate_valid_cnt", q_valid, 16);
    chk("gate_overrun", q_ov, 0);
    chk("gate_tap15", cap_old, 20);

    // synchronous reset mid-run, applied with clkEn low
    clear_stats();
    do_start(10);
    repeat (7) tick();
    rst = 1'b1; clkEn = 1'b0;
    tick();
    rst = 1'b0; clkEn = 1'b1;
    chk("rst_rdb", rdb1, 0);
    chk("rst_valid", dv1, 0);
    chk("rst_valid_l3", dv3, 0);
    run_out();
    chk("rst_last_cnt", q_last, 0);
    chk("rst_last_cnt_l3", q_last3, 0);
    clear_stats();
    do_start(0);
    run_out();
    chk("rst_rerun_tap0", cap_new, 0);
    chk("rst_rerun_tap15", cap_old, 17);

    // asynchronous reset between edges
    do_start(9);
    repeat (4) tick();
    #2;
    nGrst = 1'b0;
    #1;
    model_reset();
    check_all();
    nGrst = 1'b1;
    sv_dv1 = 0; sv_df1 = 0; sv_dl1 = 0; sv_dl3 = 0; sv_rdb = 0; sv_ov = 0;
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      clkEn       = ($urandom_range(0, 7) != 0);
      start       = ($urandom_range(0, 9) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      newest_addr = 5'($urandom_range(0, 31));
      tick();
    end
    rst = 1'b0; clkEn = 1'b1; start = 1'b0;
    run_out();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
